// File: rtl/rv32_exec_ctrl.sv
// rv32_exec_ctrl -- sequencing and execution core of the RV32I APB CPU.
// Holds the control FSM, the ALU and the datapath muxes. The parent block owns
// the PC, the APB address/data registers, the saved instruction and the regfile.
// All of those are loaded from the strobe/value pairs that this block drives.
//
// Ports
//   APB_PCLK, APB_PRESET         clock, synchronous active-high reset
//   instruction                  current instruction word
//   APB_prdata                   APB read data, right-justified
//   pc                           parent PC (instr addr + 4 once fetched)
//   rs0, rs1                     regfile data for instruction[19:15]/[24:20]
//   APB_pready, APB_perr         APB handshake
//   interrupt                    reserved
//   APB_psel/penable/pwrite      APB control
//   load_paddr, load_pdata,
//   load_pc, load_insr,
//   write_reg, read_reg          parent register strobes
//   APB_paddr_val, APB_pdata_val,
//   load_pc_mux, write_reg_mux   values for the strobes, 0 when strobe is low
module rv32_exec_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  APB_PCLK,
   input  logic                  APB_PRESET,
   input  logic [DATA_WIDTH-1:0] instruction,
   input  logic [DATA_WIDTH-1:0] APB_prdata,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] rs0,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic                  APB_pready,
   input  logic                  APB_perr,
   input  logic                  interrupt,
   output logic                  APB_psel,
   output logic                  APB_penable,
   output logic                  APB_pwrite,
   output logic                  load_paddr,
   output logic                  load_pdata,
   output logic                  load_pc,
   output logic                  load_insr,
   output logic                  write_reg,
   output logic                  read_reg,
   output logic [ADDR_WIDTH-1:0] APB_paddr_val,
   output logic [DATA_WIDTH-1:0] APB_pdata_val,
   output logic [ADDR_WIDTH-1:0] load_pc_mux,
   output logic [DATA_WIDTH-1:0] write_reg_mux
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [2:0] {F_ADDR, F_SETUP, F_ACCESS, EXEC, M_SETUP, M_ACCESS} state_t;

   state_t state, state_next;

   // Error responses complete a transfer exactly like a normal pready, and
   // interrupts are reserved, so neither input affects the sequencing.
   logic unused_inputs;
   assign unused_inputs = ^{APB_perr, interrupt};

   // ---------------- decode ----------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alt;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, ipc;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign alt    = instruction[30];   // funct7[5] for OP, imm[10] for shifts
   assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u  = {instruction[31:12], 12'b0};
   assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
   assign ipc    = pc - 32'd4;        // pc already points past this instruction

   // ---------------- ALU ----------------
   logic [31:0] alu_b, alu_y;
   logic [4:0]  shamt;
   logic        lt_s, lt_u, taken;

   assign alu_b = (opcode == OPC_OP) ? rs1 : imm_i;
   assign shamt = alu_b[4:0];
   assign lt_s  = $signed(rs0) < $signed(alu_b);
   assign lt_u  = rs0 < alu_b;

   always_comb begin
      case (funct3)
         3'b000:  alu_y = (opcode == OPC_OP && alt) ? rs0 - alu_b : rs0 + alu_b;
         3'b001:  alu_y = rs0 << shamt;
         3'b010:  alu_y = {31'b0, lt_s};
         3'b011:  alu_y = {31'b0, lt_u};
         3'b100:  alu_y = rs0 ^ alu_b;
         3'b101:  alu_y = alt ? 32'($signed(rs0) >>> shamt) : rs0 >> shamt;
         3'b110:  alu_y = rs0 | alu_b;
         default: alu_y = rs0 & alu_b;
      endcase
   end

   // Branches always compare rs0 against rs1 (alu_b is rs1 only for OP).
   always_comb begin
      case (funct3)
         3'b000:  taken = (rs0 == rs1);
         3'b001:  taken = (rs0 != rs1);
         3'b100:  taken = $signed(rs0) < $signed(rs1);
         3'b101:  taken = !($signed(rs0) < $signed(rs1));
         3'b110:  taken = rs0 < rs1;
         3'b111:  taken = !(rs0 < rs1);
         default: taken = 1'b0;
      endcase
   end

   logic [31:0] load_val;
   always_comb begin
      case (funct3)
         3'b000:  load_val = {{24{APB_prdata[7]}}, APB_prdata[7:0]};
         3'b001:  load_val = {{16{APB_prdata[15]}}, APB_prdata[15:0]};
         3'b100:  load_val = {24'b0, APB_prdata[7:0]};
         3'b101:  load_val = {16'b0, APB_prdata[15:0]};
         default: load_val = APB_prdata;
      endcase
   end

   // ---------------- state register ----------------
   // NOTE: state registers use non-blocking assignment so every flop samples
   // values from before the edge, independent of process evaluation order.
   always_ff @(posedge APB_PCLK) begin
      if (APB_PRESET) state <= F_ADDR;
      else            state <= state_next;
   end

   // ---------------- next state and outputs ----------------
   // NOTE: every output gets a default first, so no path leaves a value
   // unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      APB_psel      = 1'b0;
      APB_penable   = 1'b0;
      APB_pwrite    = 1'b0;
      load_paddr    = 1'b0;
      load_pdata    = 1'b0;
      load_pc       = 1'b0;
      load_insr     = 1'b0;
      write_reg     = 1'b0;
      read_reg      = 1'b0;
      APB_paddr_val = '0;
      APB_pdata_val = '0;
      load_pc_mux   = '0;
      write_reg_mux = '0;

      case (state)
         F_ADDR: begin
            load_paddr    = 1'b1;
            APB_paddr_val = pc;
            state_next    = F_SETUP;
         end
         F_SETUP: begin
            APB_psel   = 1'b1;
            state_next = F_ACCESS;
         end
         F_ACCESS: begin
            APB_psel    = 1'b1;
            APB_penable = 1'b1;
            if (APB_pready) begin
               load_insr   = 1'b1;
               load_pc     = 1'b1;
               load_pc_mux = pc + 32'd4;
               state_next  = EXEC;
            end
         end
         EXEC: begin
            read_reg   = 1'b1;
            state_next = F_ADDR;
            case (opcode)
               OPC_OP, OPC_OP_IMM: begin
                  write_reg     = 1'b1;
                  write_reg_mux = alu_y;
               end
               OPC_LUI: begin
                  write_reg     = 1'b1;
                  write_reg_mux = imm_u;
               end
               OPC_AUIPC: begin
                  write_reg     = 1'b1;
                  write_reg_mux = ipc + imm_u;
               end
               OPC_JAL: begin
                  write_reg     = 1'b1;
                  write_reg_mux = pc;
                  load_pc       = 1'b1;
                  load_pc_mux   = ipc + imm_j;
               end
               OPC_JALR: begin
                  write_reg     = 1'b1;
                  write_reg_mux = pc;
                  load_pc       = 1'b1;
                  load_pc_mux   = (rs0 + imm_i) & ~32'd1;
               end
               OPC_BRANCH: begin
                  if (taken) begin
                     load_pc     = 1'b1;
                     load_pc_mux = ipc + imm_b;
                  end
               end
               OPC_LOAD: begin
                  load_paddr    = 1'b1;
                  APB_paddr_val = rs0 + imm_i;
                  state_next    = M_SETUP;
               end
               OPC_STORE: begin
                  load_paddr    = 1'b1;
                  APB_paddr_val = rs0 + imm_s;
                  load_pdata    = 1'b1;
                  APB_pdata_val = rs1;
                  state_next    = M_SETUP;
               end
               default: ;
            endcase
         end
         M_SETUP: begin
            APB_psel   = 1'b1;
            APB_pwrite = (opcode == OPC_STORE);
         end
         M_ACCESS: begin
            APB_psel    = 1'b1;
            APB_penable = 1'b1;
            APB_pwrite  = (opcode == OPC_STORE);
            read_reg    = 1'b1;
            if (APB_pready) begin
               if (opcode == OPC_LOAD) begin
                  write_reg     = 1'b1;
                  write_reg_mux = load_val;
               end
               state_next = F_ADDR;
            end
         end
         default: state_next = F_ADDR;
      endcase

      if (state == M_SETUP) state_next = M_ACCESS;

      // While reset is held every strobe and APB control is quiet, which also
      // drops psel/penable immediately when a transfer is aborted.
      if (APB_PRESET) begin
         APB_psel      = 1'b0;
         APB_penable   = 1'b0;
         APB_pwrite    = 1'b0;
         load_paddr    = 1'b0;
         load_pdata    = 1'b0;
         load_pc       = 1'b0;
         load_insr     = 1'b0;
         write_reg     = 1'b0;
         read_reg      = 1'b0;
         APB_paddr_val = '0;
         APB_pdata_val = '0;
         load_pc_mux   = '0;
         write_reg_mux = '0;
      end
   end

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Testbench for rv32_exec_ctrl. A reference model derives every output from the
// instruction semantics and the bus phase the bench is driving; a compare
// process checks all outputs each cycle, and directed literals pin the model.
module tb_rv32_exec_ctrl;

   typedef enum {PH_RESET, PH_FADDR, PH_FSETUP, PH_FACCESS, PH_EXEC, PH_MSETUP, PH_MACCESS} ph_t;

   typedef struct packed {
      logic        psel, penable, pwrite;
      logic        load_paddr, load_pdata, load_pc, load_insr, write_reg, read_reg;
      logic [31:0] paddr_val, pdata_val, lpc_mux, wrm;
   } outs_t;

   logic        clk = 1'b0;
   logic        APB_PRESET = 1'b1;
   logic [31:0] instruction = '0, APB_prdata = '0, pc = '0, rs0 = '0, rs1 = '0;
   logic        APB_pready = 1'b0, APB_perr = 1'b0, interrupt = 1'b0;
   logic        APB_psel, APB_penable, APB_pwrite;
   logic        load_paddr, load_pdata, load_pc, load_insr, write_reg, read_reg;
   logic [31:0] APB_paddr_val, APB_pdata_val, load_pc_mux, write_reg_mux;

   int n_checks = 0;
   int n_pass   = 0;

   outs_t exp_o;
   outs_t act_o;
   logic  exp_valid = 1'b0;

   always #5 clk = ~clk;

   rv32_exec_ctrl dut (
      .APB_PCLK(clk), .APB_PRESET(APB_PRESET), .instruction(instruction),
      .APB_prdata(APB_prdata), .pc(pc), .rs0(rs0), .rs1(rs1),
      .APB_pready(APB_pready), .APB_perr(APB_perr), .interrupt(interrupt),
      .APB_psel(APB_psel), .APB_penable(APB_penable), .APB_pwrite(APB_pwrite),
      .load_paddr(load_paddr), .load_pdata(load_pdata), .load_pc(load_pc),
      .load_insr(load_insr), .write_reg(write_reg), .read_reg(read_reg),
      .APB_paddr_val(APB_paddr_val), .APB_pdata_val(APB_pdata_val),
      .load_pc_mux(load_pc_mux), .write_reg_mux(write_reg_mux)
   );

   always_comb begin
      act_o            = '0;
      act_o.psel       = APB_psel;
      act_o.penable    = APB_penable;
      act_o.pwrite     = APB_pwrite;
      act_o.load_paddr = load_paddr;
      act_o.load_pdata = load_pdata;
      act_o.load_pc    = load_pc;
      act_o.load_insr  = load_insr;
      act_o.write_reg  = write_reg;
      act_o.read_reg   = read_reg;
      act_o.paddr_val  = APB_paddr_val;
      act_o.pdata_val  = APB_pdata_val;
      act_o.lpc_mux    = load_pc_mux;
      act_o.wrm        = write_reg_mux;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic alt, input logic is_op);
      int unsigned sh;
      sh = int'(b[4:0]);
      case (f3)
         3'd0: return (is_op && alt) ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic br_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic outs_t model(input ph_t ph, input logic [31:0] ins, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] prd, input logic rdy);
      outs_t o;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] ii, is, ib, iu, ij, ipc;
      o   = '0;
      op  = ins[6:0];
      f3  = ins[14:12];
      ii  = {{20{ins[31]}}, ins[31:20]};
      is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu  = {ins[31:12], 12'h000};
      ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      ipc = pcv - 32'd4;
      case (ph)
         PH_FADDR: begin o.load_paddr = 1; o.paddr_val = pcv; end
         PH_FSETUP: o.psel = 1;
         PH_FACCESS: begin
            o.psel = 1; o.penable = 1;
            if (rdy) begin o.load_insr = 1; o.load_pc = 1; o.lpc_mux = pcv + 32'd4; end
         end
         PH_EXEC: begin
            o.read_reg = 1;
            case (op)
               7'h33: begin o.write_reg = 1; o.wrm = alu_ref(a, b, f3, ins[30], 1'b1); end
               7'h13: begin o.write_reg = 1; o.wrm = alu_ref(a, ii, f3, ins[30], 1'b0); end
               7'h37: begin o.write_reg = 1; o.wrm = iu; end
               7'h17: begin o.write_reg = 1; o.wrm = ipc + iu; end
               7'h6F: begin o.write_reg = 1; o.wrm = pcv; o.load_pc = 1; o.lpc_mux = ipc + ij; end
               7'h67: begin o.write_reg = 1; o.wrm = pcv; o.load_pc = 1; o.lpc_mux = (a + ii) & 32'hFFFF_FFFE; end
               7'h63: if (br_ref(a, b, f3)) begin o.load_pc = 1; o.lpc_mux = ipc + ib; end
               7'h03: begin o.load_paddr = 1; o.paddr_val = a + ii; end
               7'h23: begin o.load_paddr = 1; o.paddr_val = a + is; o.load_pdata = 1; o.pdata_val = b; end
               default: ;
            endcase
         end
         PH_MSETUP: begin o.psel = 1; o.pwrite = (op == 7'h23); end
         PH_MACCESS: begin
            o.psel = 1; o.penable = 1; o.pwrite = (op == 7'h23); o.read_reg = 1;
            if (rdy && op == 7'h03) begin
               o.write_reg = 1;
               case (f3)
                  3'd0: o.wrm = {{24{prd[7]}}, prd[7:0]};
                  3'd1: o.wrm = {{16{prd[15]}}, prd[15:0]};
                  3'd4: o.wrm = {24'h0, prd[7:0]};
                  3'd5: o.wrm = {16'h0, prd[15:0]};
                  default: o.wrm = prd;
               endcase
            end
         end
         default: ;  // reset: everything quiet
      endcase
      return o;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (exp_valid) begin
         check("psel",       32'(act_o.psel),       32'(exp_o.psel));
         check("penable",    32'(act_o.penable),    32'(exp_o.penable));
         check("pwrite",     32'(act_o.pwrite),     32'(exp_o.pwrite));
         check("load_paddr", 32'(act_o.load_paddr), 32'(exp_o.load_paddr));
         check("load_pdata", 32'(act_o.load_pdata), 32'(exp_o.load_pdata));
         check("load_pc",    32'(act_o.load_pc),    32'(exp_o.load_pc));
         check("load_insr",  32'(act_o.load_insr),  32'(exp_o.load_insr));
         check("write_reg",  32'(act_o.write_reg),  32'(exp_o.write_reg));
         check("read_reg",   32'(act_o.read_reg),   32'(exp_o.read_reg));
         check("paddr_val",  act_o.paddr_val,       exp_o.paddr_val);
         check("pdata_val",  act_o.pdata_val,       exp_o.pdata_val);
         check("load_pc_mux", act_o.lpc_mux,        exp_o.lpc_mux);
         check("write_reg_mux", act_o.wrm,          exp_o.wrm);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input ph_t ph, input logic rdy, input logic [31:0] pcv,
                       input logic [31:0] prd, output outs_t snap);
      APB_PRESET = (ph == PH_RESET);
      APB_pready = rdy;
      pc         = pcv;
      APB_prdata = prd;
      exp_o      = model(ph, instruction, pcv, rs0, rs1, prd, rdy);
      exp_valid  = 1'b1;
      @(negedge clk);
      snap = act_o;
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [31:0] iaddr, input logic [31:0] ins,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] data,
                            input int fwaits, input int mwaits, output int cycles,
                            output outs_t s_fa, output outs_t s_ex,
                            output outs_t s_ms, output outs_t s_ma);
      outs_t s;
      instruction = ins; rs0 = a; rs1 = b;
      cycles = 0; s_ms = '0; s_ma = '0;
      step(PH_FADDR, 1'b0, iaddr, 32'h0, s_fa);  cycles++;
      step(PH_FSETUP, 1'b0, iaddr, 32'h0, s);    cycles++;
      for (int i = 0; i < fwaits; i++) begin step(PH_FACCESS, 1'b0, iaddr, ins, s); cycles++; end
      step(PH_FACCESS, 1'b1, iaddr, ins, s);     cycles++;
      step(PH_EXEC, 1'b0, iaddr + 32'd4, 32'h0, s_ex); cycles++;
      if (ins[6:0] == 7'h03 || ins[6:0] == 7'h23) begin
         step(PH_MSETUP, 1'b0, iaddr + 32'd4, data, s_ms); cycles++;
         for (int i = 0; i < mwaits; i++) begin step(PH_MACCESS, 1'b0, iaddr + 32'd4, data, s); cycles++; end
         step(PH_MACCESS, 1'b1, iaddr + 32'd4, data, s_ma); cycles++;
      end
   endtask

   initial begin
      outs_t fa, ex, ms, ma, s;
      int    cyc;

      step(PH_RESET, 1'b1, 32'h0, 32'h0, s);
      step(PH_RESET, 1'b1, 32'h0, 32'h0, s);
      check("reset_quiet", 32'({s.psel, s.load_paddr, s.write_reg, s.read_reg}), 32'h0);

      // addi x1,x0,5
      run_instr(32'h0, 32'h00500093, 32'h0, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("addi_fetch_addr", fa.paddr_val, 32'h0);
      check("addi_wr", 32'(ex.write_reg), 32'h1);
      check("addi_val", ex.wrm, 32'h5);
      check("addi_cycles", 32'(cyc), 32'd4);

      // sub x3,x1,x2
      run_instr(32'h4, 32'h402081B3, 32'd3, 32'd5, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("sub_val", ex.wrm, 32'hFFFF_FFFE);

      // srai x1,x1,4
      run_instr(32'h8, 32'h4040D093, 32'h8000_0000, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("srai_val", ex.wrm, 32'hF800_0000);

      // beq x1,x2,-8 taken
      run_instr(32'h100, 32'hFE208CE3, 32'd7, 32'd7, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("beq_load_pc", 32'(ex.load_pc), 32'h1);
      check("beq_target", ex.lpc_mux, 32'h0000_00F8);

      // bne x1,x2,-8 with equal operands: not taken
      run_instr(32'h100, 32'hFE209CE3, 32'd7, 32'd7, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("bne_no_load_pc", 32'(ex.load_pc), 32'h0);

      // blt x1,x2,+8 signed, one fetch wait state
      run_instr(32'h200, 32'h0020C463, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, cyc, fa, ex, ms, ma);
      check("blt_target", ex.lpc_mux, 32'h0000_0208);
      check("blt_cycles", 32'(cyc), 32'd5);

      // lb x5,3(x1), two memory wait states
      run_instr(32'h10, 32'h00308283, 32'h2000, 32'h0, 32'h80, 0, 2, cyc, fa, ex, ms, ma);
      check("lb_addr", ex.paddr_val, 32'h2003);
      check("lb_pwrite", 32'({ms.pwrite, ma.pwrite}), 32'h0);
      check("lb_val", ma.wrm, 32'hFFFF_FF80);
      check("lb_cycles", 32'(cyc), 32'd8);

      // lhu x1,0(x1)
      run_instr(32'h14, 32'h0000D083, 32'h2100, 32'h0, 32'hFFFF_8001, 0, 0, cyc, fa, ex, ms, ma);
      check("lhu_val", ma.wrm, 32'h0000_8001);

      // sw x2,4(x1)
      run_instr(32'h18, 32'h0020A223, 32'h3000, 32'hDEAD_BEEF, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("sw_addr", ex.paddr_val, 32'h3004);
      check("sw_data", ex.pdata_val, 32'hDEAD_BEEF);
      check("sw_pwrite", 32'({ms.pwrite, ma.pwrite}), 32'h3);
      check("sw_cycles", 32'(cyc), 32'd6);

      // jalr x1,0(x1)
      run_instr(32'h1C, 32'h000080E7, 32'h101, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("jalr_link", ex.wrm, 32'h20);
      check("jalr_target", ex.lpc_mux, 32'h100);

      // lui x1,0x12345 and jal x1,+16
      run_instr(32'h30, 32'h123450B7, 32'h0, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("lui_val", ex.wrm, 32'h1234_5000);
      run_instr(32'h40, 32'h010000EF, 32'h0, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("jal_link", ex.wrm, 32'h44);
      check("jal_target", ex.lpc_mux, 32'h50);

      // reset asserted while the fetch is stalled in its access phase
      instruction = 32'h00500093;
      step(PH_FADDR, 1'b0, 32'h80, 32'h0, s);
      step(PH_FSETUP, 1'b0, 32'h80, 32'h0, s);
      step(PH_FACCESS, 1'b0, 32'h80, 32'h0, s);
      check("stall_penable", 32'(s.penable), 32'h1);
      step(PH_RESET, 1'b0, 32'h80, 32'h0, s);
      run_instr(32'h80, 32'h00500093, 32'h0, 32'h0, 32'h0, 0, 0, cyc, fa, ex, ms, ma);
      check("abort_psel", 32'(fa.psel), 32'h0);
      check("abort_restart", 32'(fa.load_paddr), 32'h1);
      check("abort_cycles", 32'(cyc), 32'd4);

      exp_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32_exec_ctrl.md
Name: rv32_exec_ctrl

Overview:
- Sequencing and execution core of the RV32I APB CPU: ALU, control FSM and datapath muxes in one block.
- Fetches instructions over APB, decodes them, computes results, branch/jump targets and load/store addresses, and drives load strobes to the parent.
- Parent owns the PC, APB_paddr/APB_pdata registers, saved-instruction register, regfile and halt logic.

Parameters:
- ADDR_WIDTH, 32, APB address width (only 32 supported).
- DATA_WIDTH, 32, APB data width (only 32 supported).

Ports:
- APB_PCLK  in  1  clock; all state on rising edge.
- APB_PRESET  in  1  synchronous, active-high reset.
- instruction  in  32  current instruction (APB_prdata while load_insr, else saved copy).
- APB_prdata  in  32  APB read data; addressed item right-justified in bits [7:0]/[15:0]/[31:0].
- pc  in  32  parent PC; after fetch it holds the next-instruction address (instr addr + 4).
- rs0, rs1  in  32  regfile read data for instruction[19:15] and instruction[24:20].
- APB_pready, APB_perr, interrupt  in  1  APB ready, APB error, interrupt (reserved).
- APB_psel, APB_penable, APB_pwrite  out  1  APB control.
- load_paddr, load_pdata, load_pc, load_insr, write_reg, read_reg  out  1  parent register strobes.
- APB_paddr_val, APB_pdata_val, load_pc_mux, write_reg_mux  out  32  values for those strobes.

Behaviour:
- States: F_ADDR, F_SETUP, F_ACCESS, EXEC, M_SETUP, M_ACCESS. Reset -> F_ADDR, all strobes and APB outputs 0.
- Reset mid-transfer aborts the transfer; psel/penable are 0 the next cycle.
- F_ADDR: load_paddr=1, APB_paddr_val=pc; next F_SETUP.
- F_SETUP: psel=1, penable=0; next F_ACCESS.
- F_ACCESS: psel=1, penable=1, pwrite=0. Wait while !pready. On pready: load_insr=1, load_pc=1, load_pc_mux=pc+4; next EXEC.
- EXEC: read_reg=1. Let ipc=pc-4. Immediates are sign-extended per RV32I I/S/B/U/J formats. Decode by instruction[6:0]:
  - OP/OP-IMM: write_reg=1, write_reg_mux=ALU(rs0, rs1 or imm_i).
  - LUI: write_reg_mux=imm_u. AUIPC: write_reg_mux=ipc+imm_u.
  - JAL: write_reg_mux=pc; load_pc=1, load_pc_mux=ipc+imm_j.
  - JALR: write_reg_mux=pc; load_pc=1, load_pc_mux=(rs0+imm_i)&~1.
  - BRANCH: if ALU compare true, load_pc=1, load_pc_mux=ipc+imm_b. No register write.
  - LOAD: load_paddr=1, APB_paddr_val=rs0+imm_i; next M_SETUP.
  - STORE: load_paddr=1, APB_paddr_val=rs0+imm_s; load_pdata=1, APB_pdata_val=rs1; next M_SETUP.
  - SYSTEM/unknown: no-op.
  - Next state F_ADDR unless LOAD/STORE.
- M_SETUP: psel=1, penable=0, pwrite=1 iff STORE.
- M_ACCESS: psel=1, penable=1, pwrite held; read_reg=1. On pready:
  - LOAD: write_reg=1, write_reg_mux=prdata extended per funct3: 000 LB sign [7:0]; 001 LH sign [15:0]; 010 LW; 100 LBU; 101 LHU; others as LW.
  - Next F_ADDR.
- APB_perr: transfer treated as complete, no retry. interrupt: ignored.
- write_reg to rd=x0 is still asserted; the regfile discards it.
- ALU ops (32-bit, wrap-around): ADD, SUB (OP only, funct7[5]=1), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]/imm[10]), OR, AND. Shift amount is operand B [4:0].
- Branch compare: BEQ, BNE, BLT, BGE signed; BLTU, BGEU unsigned; funct3 010/011 never taken.
- Unused value outputs are 0 when their strobe is low.
- Latency with zero-wait pready: 4 cycles per non-memory instruction, 6 per load/store. Each wait cycle adds 1.

Test Plan:
- Reset then pready=1, pc=0, instruction=0x00500093 (addi x1,x0,5), rs0=0 -> F_ADDR paddr_val=0; EXEC write_reg=1, write_reg_mux=5; 4 cycles total.
- sub: rs0=3, rs1=5, funct7[5]=1 -> write_reg_mux=0xFFFFFFFE. srai: rs0=0x80000000, shamt 4 -> 0xF8000000.
- beq taken: rs0=rs1=7, pc=0x104, imm_b=-8 -> load_pc_mux=0xF8. bne with equal operands -> no load_pc in EXEC.
- lb: rs0=0x2000, imm=3, prdata=0x80 -> paddr_val=0x2003, pwrite=0 in M phases, write_reg_mux=0xFFFFFF80. Hold pready=0 for 2 cycles -> penable stays high, completes 2 cycles later.
- sw: rs0=0x3000, rs1=0xDEADBEEF, imm_s=4 -> paddr_val=0x3004, pdata_val=0xDEADBEEF, pwrite=1 in M_SETUP/M_ACCESS.
- jalr: pc=0x20, rs0=0x101, imm=0 -> write_reg_mux=0x20, load_pc_mux=0x100. Assert reset during F_ACCESS -> psel=0 next cycle, state F_ADDR.
